// File: rtl/data_bus.sv
// rtl/data_bus.sv - data-side responder: word RAM plus MMIO UART transmitter and 64-bit cycle counter
// Loads are combinational; stores and all MMIO side effects commit on the rising clock edge.

module data_bus_tx_fifo #(
  parameter int DEPTH = 4
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       push,
  input  logic       pop,
  input  logic [7:0] push_data,
  output logic [7:0] pop_data,
  output logic       full,
  output logic       empty,
  output logic [2:0] count
);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [7:0]    slot_q [DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [2:0]    count_q, count_d;
  logic          push_ok;
  logic          pop_ok;

  function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign full     = (count_q == 3'(DEPTH));
  assign empty    = (count_q == 3'd0);
  assign count    = count_q;
  assign pop_data = slot_q[rd_ptr_q];
  // A push while full is dropped even if a pop frees a slot on the same edge.
  assign push_ok  = push & ~full;
  assign pop_ok   = pop & ~empty;

  always_comb begin
    wr_ptr_d = push_ok ? next_ptr(wr_ptr_q) : wr_ptr_q;
    rd_ptr_d = pop_ok ? next_ptr(rd_ptr_q) : rd_ptr_q;
    count_d  = count_q + {2'b00, push_ok} - {2'b00, pop_ok};
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= 3'd0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clock) begin
    if (push_ok) slot_q[wr_ptr_q] <= push_data;
  end
endmodule

module data_bus #(
  parameter int XLEN       = 32,
  parameter int RAM_WORDS  = 1024,
  parameter int FIFO_DEPTH = 4,
  parameter int CLK_DIV    = 868
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            mem_load,
  input  logic            mem_store,
  input  logic [XLEN-1:0] address,
  input  logic [XLEN-1:0] store_data,
  output logic [XLEN-1:0] load_data,
  output logic            uart_tx
);
  localparam int RAM_AW = $clog2(RAM_WORDS);
  localparam int BAUD_W = $clog2(CLK_DIV);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_START = 2'd1;
  localparam logic [1:0] ST_DATA  = 2'd2;
  localparam logic [1:0] ST_STOP  = 2'd3;

  logic [XLEN-1:0]   ram_q [RAM_WORDS];
  logic [RAM_AW-1:0] ram_idx;
  logic              is_mmio;
  logic [1:0]        reg_sel;
  logic              ram_we;
  logic              txdata_wr;
  logic              status_wr;
  logic              cyclo_rd;

  logic [1:0]        state_q, state_d;
  logic [BAUD_W-1:0] baud_q, baud_d;
  logic [2:0]        bit_q, bit_d;
  logic [7:0]        shift_q, shift_d;
  logic              overflow_q, overflow_d;
  logic [63:0]       cycle_q, cycle_d;
  logic [31:0]       snap_q, snap_d;
  logic              baud_end;
  logic              busy;

  logic              fifo_pop;
  logic [7:0]        fifo_rdata;
  logic              fifo_full;
  logic              fifo_empty;
  logic [2:0]        fifo_count;
  logic              unused_addr_bits;

  assign is_mmio   = address[31];
  assign reg_sel   = address[3:2];
  assign ram_idx   = address[RAM_AW+1:2];
  assign ram_we    = mem_store & ~is_mmio;
  assign txdata_wr = mem_store & is_mmio & (reg_sel == 2'd0);
  assign status_wr = mem_store & is_mmio & (reg_sel == 2'd1);
  assign cyclo_rd  = mem_load & is_mmio & (reg_sel == 2'd2);
  assign baud_end  = (baud_q == BAUD_W'(CLK_DIV - 1));
  assign busy      = (state_q != ST_IDLE) | ~fifo_empty;
  assign unused_addr_bits = ^{address[30:RAM_AW+2], address[1:0]};

  data_bus_tx_fifo #(.DEPTH(FIFO_DEPTH)) u_tx_fifo (
    .clock     (clock),
    .reset     (reset),
    .push      (txdata_wr),
    .pop       (fifo_pop),
    .push_data (store_data[7:0]),
    .pop_data  (fifo_rdata),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  always_ff @(posedge clock) begin
    if (ram_we) ram_q[ram_idx] <= store_data;
  end

  always_comb begin
    state_d    = state_q;
    baud_d     = baud_q;
    bit_d      = bit_q;
    shift_d    = shift_q;
    fifo_pop   = 1'b0;
    overflow_d = overflow_q;
    snap_d     = snap_q;
    cycle_d    = cycle_q + 64'd1;

    case (state_q)
      ST_IDLE: begin
        if (!fifo_empty) begin
          fifo_pop = 1'b1;
          shift_d  = fifo_rdata;
          baud_d   = '0;
          state_d  = ST_START;
        end
      end
      ST_START: begin
        if (baud_end) begin
          baud_d  = '0;
          bit_d   = 3'd0;
          state_d = ST_DATA;
        end else begin
          baud_d = baud_q + 1'b1;
        end
      end
      ST_DATA: begin
        if (baud_end) begin
          baud_d  = '0;
          shift_d = {1'b0, shift_q[7:1]};
          if (bit_q == 3'd7) begin
            bit_d   = 3'd0;
            state_d = ST_STOP;
          end else begin
            bit_d = bit_q + 3'd1;
          end
        end else begin
          baud_d = baud_q + 1'b1;
        end
      end
      default: begin
        if (baud_end) begin
          baud_d = '0;
          // Chain straight into the next start bit so queued bytes leave with no idle gap.
          if (!fifo_empty) begin
            fifo_pop = 1'b1;
            shift_d  = fifo_rdata;
            state_d  = ST_START;
          end else begin
            state_d = ST_IDLE;
          end
        end else begin
          baud_d = baud_q + 1'b1;
        end
      end
    endcase

    if (txdata_wr && fifo_full) overflow_d = 1'b1;
    if (status_wr) overflow_d = 1'b0;
    if (cyclo_rd) snap_d = cycle_q[63:32];
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      baud_q     <= '0;
      bit_q      <= 3'd0;
      shift_q    <= 8'd0;
      overflow_q <= 1'b0;
      cycle_q    <= 64'd0;
      snap_q     <= 32'd0;
    end else begin
      state_q    <= state_d;
      baud_q     <= baud_d;
      bit_q      <= bit_d;
      shift_q    <= shift_d;
      overflow_q <= overflow_d;
      cycle_q    <= cycle_d;
      snap_q     <= snap_d;
    end
  end

  always_comb begin
    case (state_q)
      ST_START: uart_tx = 1'b0;
      ST_DATA:  uart_tx = shift_q[0];
      default:  uart_tx = 1'b1;
    endcase
  end

  always_comb begin
    load_data = '0;
    if (!is_mmio) begin
      load_data = ram_q[ram_idx];
    end else begin
      case (reg_sel)
        2'd1:    load_data = {{(XLEN-6){1'b0}}, fifo_count, overflow_q, busy, fifo_full};
        2'd2:    load_data = cycle_q[31:0];
        2'd3:    load_data = snap_q;
        default: load_data = '0;
      endcase
    end
  end
endmodule

// File: tb/tb_data_bus.sv
// tb/tb_data_bus.sv - randomized and directed bench for data_bus against a frame-level behavioural model
module tb_data_bus;
  localparam int RAM_WORDS  = 64;
  localparam int RAM_AW     = 6;
  localparam int FIFO_DEPTH = 4;
  localparam int CLK_DIV    = 4;

  logic        clock = 1'b0;
  logic        reset;
  logic        mem_load;
  logic        mem_store;
  logic [31:0] address;
  logic [31:0] store_data;
  logic [31:0] load_data;
  logic        uart_tx;

  int checks = 0;
  int errors = 0;

  data_bus #(
    .XLEN(32), .RAM_WORDS(RAM_WORDS), .FIFO_DEPTH(FIFO_DEPTH), .CLK_DIV(CLK_DIV)
  ) dut (
    .clock      (clock),
    .reset      (reset),
    .mem_load   (mem_load),
    .mem_store  (mem_store),
    .address    (address),
    .store_data (store_data),
    .load_data  (load_data),
    .uart_tx    (uart_tx)
  );

  always #5 clock = ~clock;

  // Behavioural model: byte queue, frame position counter, plain counters.
  logic [31:0] m_ram [RAM_WORDS];
  bit          m_valid [RAM_WORDS];
  logic [7:0]  m_q [$];
  logic [7:0]  m_sent [$];
  bit          m_active = 0;
  int          m_pos = 0;
  logic [7:0]  m_byte = 8'h00;
  bit          m_ovf = 0;
  logic [63:0] m_cyc = 0;
  logic [31:0] m_snap = 0;
  bit          m_ready = 0;
  int          pre;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic m_tx();
    int b;
    if (!m_active) return 1'b1;
    b = m_pos / CLK_DIV;
    if (b == 0) return 1'b0;
    if (b == 9) return 1'b1;
    return m_byte[b-1];
  endfunction

  function automatic logic [31:0] m_status();
    logic [2:0] cnt;
    cnt = 3'(m_q.size());
    return {26'd0, cnt, m_ovf, (m_active || m_q.size() != 0), (m_q.size() == FIFO_DEPTH)};
  endfunction

  always @(posedge clock) begin
    if (mem_store && !address[31]) begin
      m_ram[address[RAM_AW+1:2]] = store_data;
      m_valid[address[RAM_AW+1:2]] = 1;
    end
    if (reset) begin
      m_q.delete();
      m_active = 0;
      m_pos = 0;
      m_ovf = 0;
      m_cyc = 0;
      m_snap = 0;
      m_ready = 1;
    end else begin
      pre = m_q.size();
      if (m_active) begin
        m_pos++;
        if (m_pos == 10 * CLK_DIV) m_active = 0;
      end
      if (!m_active && pre > 0) begin
        m_byte = m_q.pop_front();
        m_sent.push_back(m_byte);
        m_active = 1;
        m_pos = 0;
      end
      if (mem_store && address[31] && address[3:2] == 2'd0) begin
        if (pre < FIFO_DEPTH) m_q.push_back(store_data[7:0]);
        else m_ovf = 1;
      end
      if (mem_store && address[31] && address[3:2] == 2'd1) m_ovf = 0;
      if (mem_load && address[31] && address[3:2] == 2'd2) m_snap = m_cyc[63:32];
      m_cyc = m_cyc + 64'd1;
    end
  end

  always @(negedge clock) begin
    if (m_ready) begin
      check("uart_tx", uart_tx, m_tx());
      if (!address[31]) begin
        if (m_valid[address[RAM_AW+1:2]]) check("ram_load", load_data, m_ram[address[RAM_AW+1:2]]);
      end else begin
        case (address[3:2])
          2'd0: check("txdata_load", load_data, 32'd0);
          2'd1: check("status_load", load_data, m_status());
          2'd2: check("cyclo_load", load_data, m_cyc[31:0]);
          default: check("cychi_load", load_data, m_snap);
        endcase
      end
    end
  end

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic idle();
    mem_load = 0;
    mem_store = 0;
    address = 32'h0;
    store_data = 32'h0;
  endtask

  int wave [10] = '{0, 1, 0, 1, 0, 1, 0, 1, 0, 1};
  logic [31:0] a;
  int r;

  initial begin
    reset = 1;
    idle();
    repeat (3) step();

    // Cycle counter and MMIO odds and ends
    reset = 0;
    mem_load = 1;
    address = 32'h8000_0008;
    @(negedge clock) check("cyclo_first", load_data, 32'd0);
    repeat (100) step();
    @(negedge clock) check("cyclo_100", load_data, 32'd100);
    step(); address = 32'h8000_000C;
    @(negedge clock) check("cychi_after_lo", load_data, 32'd0);
    step(); address = 32'h8000_0018;
    @(negedge clock) check("cyclo_alias", load_data, 32'd102);
    step(); mem_load = 0; mem_store = 1; address = 32'h8000_000C; store_data = 32'hFFFF_FFFF;
    step(); mem_store = 0; mem_load = 1;
    @(negedge clock) check("cychi_store_ignored", load_data, 32'd0);
    step(); address = 32'h8000_0000;
    @(negedge clock) check("txdata_read", load_data, 32'd0);

    // RAM
    step(); idle(); mem_store = 1; address = 32'h10; store_data = 32'h1234_5678;
    step(); mem_store = 0; mem_load = 1;
    @(negedge clock) check("ram_basic", load_data, 32'h1234_5678);
    step(); address = 32'h10 + 4 * RAM_WORDS;
    @(negedge clock) check("ram_alias", load_data, 32'h1234_5678);
    step(); mem_load = 0; mem_store = 1; address = 32'h10; store_data = 32'hDEAD_BEEF;
    @(negedge clock) check("ram_store_cycle_old", load_data, 32'h1234_5678);
    step(); mem_store = 0;
    @(negedge clock) check("ram_new", load_data, 32'hDEAD_BEEF);

    // Single byte 0x55
    step(); idle(); mem_store = 1; address = 32'h8000_0000; store_data = 32'h55;
    step(); idle(); mem_load = 1; address = 32'h8000_0004;
    @(negedge clock) check("tx_idle_before_pop", uart_tx, 1'b1);
    for (int k = 0; k < 40; k++) begin
      @(negedge clock) check("tx_0x55_wave", uart_tx, wave[k / CLK_DIV]);
    end
    @(negedge clock) check("status_after_frame", load_data, 32'd0);

    // FIFO overflow
    m_sent.delete();
    for (int i = 1; i <= 6; i++) begin
      step(); idle(); mem_store = 1; address = 32'h8000_0000; store_data = i;
    end
    step(); idle(); mem_load = 1; address = 32'h8000_0004;
    @(negedge clock) check("status_overflow", load_data, 32'h27);
    step(); mem_load = 0; mem_store = 1; store_data = 32'h0;
    step(); mem_store = 0; mem_load = 1;
    @(negedge clock) check("status_ovf_cleared", load_data, 32'h23);
    repeat (240) step();
    check("sent_count", m_sent.size(), 5);
    for (int i = 0; i < 5 && i < m_sent.size(); i++) check("sent_byte", m_sent[i], i + 1);

    // Reset during DATA bit 3 with two bytes queued
    step(); idle(); mem_store = 1; address = 32'h8000_0000; store_data = 32'hA1;
    step(); store_data = 32'hA2;
    step(); store_data = 32'hA3;
    step(); idle();
    repeat (16) step();
    reset = 1;
    step(); reset = 0; mem_load = 1; address = 32'h8000_0004;
    @(negedge clock) check("reset_status", load_data, 32'd0);
    check("reset_tx", uart_tx, 1'b1);
    step(); address = 32'h10;
    repeat (100) step();
    @(negedge clock) check("ram_kept_over_reset", load_data, 32'hDEAD_BEEF);

    // Randomized traffic
    for (int n = 0; n < 3000; n++) begin
      step(); idle(); reset = 0;
      r = $urandom_range(0, 99);
      a = $urandom;
      if (r < 25) begin
        a[31] = 0; mem_load = 1;
      end else if (r < 45) begin
        a[31] = 0; mem_store = 1; store_data = $urandom;
      end else if (r < 55) begin
        a[31] = 1; mem_load = 1;
      end else if (r < 61) begin
        a[31] = 1; a[3:2] = 2'd0; mem_store = 1; store_data = $urandom;
      end else if (r < 63) begin
        a[31] = 1; a[3:2] = 2'd1; mem_store = 1; store_data = $urandom;
      end else if (r < 64) begin
        a[31] = 1; a[3:2] = 2'd3; mem_store = 1; store_data = $urandom;
      end else if (r == 99 && $urandom_range(0, 3) == 0) begin
        reset = 1;
      end
      address = a;
    end
    step(); idle(); reset = 0;
    repeat (5) step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
